// File: rtl/avalon_ecc_mailbox_pkg.sv
// Shared types, bit positions and address helpers for the ECC mailbox.
package ecc_mailbox_pkg;

    // Sequencer states for one core run
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        BUSY    = 2'd2,
        CAPTURE = 2'd3
    } mbox_state_e;

    // CTRL register fields
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_MODE_LSB   = 4;
    localparam int CTRL_MODE_W     = 4;

    // STATUS register fields
    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_BUSY_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    // CTRL lives one below the top of the word address space
    function automatic int unsigned ctrl_offset(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

    // STATUS is the last word of the address space
    function automatic int unsigned status_offset(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/avalon_ecc_mailbox_if.sv
// Avalon-MM slave bus bundle used between the console CPU and the mailbox.
interface avalon_ecc_mailbox_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic                  avl_read;
    logic                  avl_write;
    logic                  avl_cs;
    logic [DATA_W/8-1:0]   avl_byte_en;
    logic [ADDR_W-1:0]     avl_addr;
    logic [DATA_W-1:0]     avl_writedata;
    logic [DATA_W-1:0]     avl_readdata;

    modport master (
        output avl_read, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_read, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata,
        output avl_readdata
    );
endinterface

// File: rtl/avalon_ecc_mailbox_regfile.sv
// Mailbox storage: byte-enabled operand words, captured result words,
// the CTRL register and the registered Avalon read mux.
module mbox_regfile
    import ecc_mailbox_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 8,
    parameter int ADDR_W    = 5
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wr_en,
    input  logic                          i_rd_en,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [DATA_W/8-1:0]           i_byte_en,
    input  logic                          i_busy,
    input  logic                          i_capture,
    input  logic [OUT_WORDS*DATA_W-1:0]   i_core_out,
    input  logic [DATA_W-1:0]             i_status,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [DATA_W-1:0]             o_ctrl,
    output logic [IN_WORDS*DATA_W-1:0]    o_operands,
    output logic                          o_busy_violation
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] RES_LO      = ADDR_W'(IN_WORDS);
    localparam logic [ADDR_W-1:0] RES_END     = ADDR_W'(IN_WORDS + OUT_WORDS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_offset(ADDR_W));
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_offset(ADDR_W));

    // Word 0 sits in the MSBs of both flat vectors, matching the core buses
    logic [IN_WORDS*DATA_W-1:0]  r_op;
    logic [OUT_WORDS*DATA_W-1:0] r_res;
    logic [DATA_W-1:0]           r_ctrl;
    logic [DATA_W-1:0]           r_rdata;

    logic                        w_hit_op;
    logic                        w_hit_res;
    logic                        w_hit_ctrl;
    logic                        w_hit_status;
    logic                        w_op_wr;
    logic                        w_ctrl_wr;
    logic                        w_mode_change;
    int                          w_op_idx;
    int                          w_res_idx;
    int                          w_op_base;
    int                          w_res_base;
    logic [DATA_W-1:0]           w_ctrl_merge;
    logic [DATA_W-1:0]           w_ctrl_nxt;
    logic [DATA_W-1:0]           w_rd_mux;

    assign w_hit_op     = (i_addr < RES_LO);
    assign w_hit_res    = (i_addr >= RES_LO) && (i_addr < RES_END);
    assign w_hit_ctrl   = (i_addr == CTRL_ADDR);
    assign w_hit_status = (i_addr == STATUS_ADDR);

    // Indices are clamped to 0 outside their window so part-selects stay in range
    assign w_op_idx   = w_hit_op  ? int'(i_addr) : 0;
    assign w_res_idx  = w_hit_res ? (int'(i_addr) - IN_WORDS) : 0;
    assign w_op_base  = (IN_WORDS  - 1 - w_op_idx)  * DATA_W;
    assign w_res_base = (OUT_WORDS - 1 - w_res_idx) * DATA_W;

    // Operands are frozen while a run is in flight
    assign w_op_wr   = i_wr_en && w_hit_op && !i_busy;
    assign w_ctrl_wr = i_wr_en && w_hit_ctrl;

    // A byte-0 CTRL write that would alter MODE counts as a mode write
    assign w_mode_change = i_byte_en[0] &&
        (i_wdata[CTRL_MODE_LSB +: CTRL_MODE_W] != r_ctrl[CTRL_MODE_LSB +: CTRL_MODE_W]);

    // Illegal accesses during a run: operand writes, mode changes, re-start
    assign o_busy_violation = i_busy && i_wr_en &&
        ((w_hit_op && (|i_byte_en)) ||
         (w_hit_ctrl && i_byte_en[0] && (i_wdata[CTRL_START_BIT] || w_mode_change)));

    // Byte-lane merge of a CTRL write over the current value
    always_comb begin
        w_ctrl_merge = r_ctrl;
        for (int b = 0; b < BE_W; b++) begin
            if (w_ctrl_wr && i_byte_en[b]) begin
                w_ctrl_merge[b*8 +: 8] = i_wdata[b*8 +: 8];
            end else begin
                w_ctrl_merge[b*8 +: 8] = r_ctrl[b*8 +: 8];
            end
        end
    end

    // START is never stored; MODE holds its value while the core is running
    assign w_ctrl_nxt = {
        w_ctrl_merge[DATA_W-1:CTRL_MODE_LSB+CTRL_MODE_W],
        (i_busy ? r_ctrl[CTRL_MODE_LSB +: CTRL_MODE_W]
                : w_ctrl_merge[CTRL_MODE_LSB +: CTRL_MODE_W]),
        w_ctrl_merge[CTRL_MODE_LSB-1:CTRL_START_BIT+1],
        1'b0
    };

    // Operand storage with per-byte write enables
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op <= '0;
        end else if (w_op_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_byte_en[b]) begin
                    r_op[w_op_base + b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Result words are loaded only by the sequencer's capture cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_res <= '0;
        end else if (i_capture) begin
            r_res <= i_core_out;
        end
    end

    // CTRL register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
        end
    end

    // Address decode for reads; unmapped addresses return zero
    always_comb begin
        w_rd_mux = '0;
        if (w_hit_op) begin
            w_rd_mux = r_op[w_op_base +: DATA_W];
        end else if (w_hit_res) begin
            w_rd_mux = r_res[w_res_base +: DATA_W];
        end else if (w_hit_ctrl) begin
            w_rd_mux = r_ctrl;
        end else if (w_hit_status) begin
            w_rd_mux = i_status;
        end else begin
            w_rd_mux = '0;
        end
    end

    // One-cycle read latency; data holds between reads
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign o_rdata    = r_rdata;
    assign o_ctrl     = r_ctrl;
    assign o_operands = r_op;

endmodule

// File: rtl/avalon_ecc_mailbox.sv
// Avalon-MM mailbox that sequences one ECC core run per START and keeps
// sticky DONE/ERR status with an optional level interrupt.
module avalon_ecc_mailbox
    import ecc_mailbox_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 8,
    parameter int ADDR_W    = 5
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    avalon_ecc_mailbox_if.slave           avl,
    output logic                          o_irq,
    output logic [DATA_W-1:0]             o_export_data,
    output logic                          o_core_start,
    output logic [3:0]                    o_core_mode,
    output logic [IN_WORDS*DATA_W-1:0]    o_core_in,
    input  logic [OUT_WORDS*DATA_W-1:0]   i_core_out,
    input  logic                          i_core_done
);
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_offset(ADDR_W));
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_offset(ADDR_W));

    mbox_state_e       r_state;
    logic              r_core_start;
    logic              r_done;
    logic              r_err;

    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_capture;
    logic              w_start_req;
    logic              w_status_wr;
    logic              w_clr_done;
    logic              w_clr_err;
    logic              w_busy_violation;
    logic [DATA_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rdata;

    assign w_wr_en   = avl.avl_cs & avl.avl_write;
    assign w_rd_en   = avl.avl_cs & avl.avl_read;
    assign w_busy    = (r_state != IDLE);
    assign w_capture = (r_state == CAPTURE);

    assign w_start_req = w_wr_en && (avl.avl_addr == CTRL_ADDR) &&
                         avl.avl_byte_en[0] && avl.avl_writedata[CTRL_START_BIT];

    assign w_status_wr = w_wr_en && (avl.avl_addr == STATUS_ADDR) && avl.avl_byte_en[0];
    assign w_clr_done  = w_status_wr && avl.avl_writedata[STAT_DONE_BIT];
    assign w_clr_err   = w_status_wr && avl.avl_writedata[STAT_ERR_BIT];

    // Assemble the STATUS word; unused bits read as zero
    always_comb begin
        w_status                = '0;
        w_status[STAT_DONE_BIT] = r_done;
        w_status[STAT_BUSY_BIT] = w_busy;
        w_status[STAT_ERR_BIT]  = r_err;
    end

    mbox_regfile #(
        .DATA_W    (DATA_W),
        .IN_WORDS  (IN_WORDS),
        .OUT_WORDS (OUT_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_regfile (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_wr_en          (w_wr_en),
        .i_rd_en          (w_rd_en),
        .i_addr           (avl.avl_addr),
        .i_wdata          (avl.avl_writedata),
        .i_byte_en        (avl.avl_byte_en),
        .i_busy           (w_busy),
        .i_capture        (w_capture),
        .i_core_out       (i_core_out),
        .i_status         (w_status),
        .o_rdata          (w_rdata),
        .o_ctrl           (w_ctrl),
        .o_operands       (o_core_in),
        .o_busy_violation (w_busy_violation)
    );

    // Run sequencer plus sticky status flags; setting a flag beats clearing it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_req) begin
                        r_state      <= LAUNCH;
                        r_core_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    r_state <= BUSY;
                end
                BUSY: begin
                    if (i_core_done) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (r_state == CAPTURE) begin
                r_done <= 1'b1;
            end else if (w_clr_done || (w_start_req && (r_state == IDLE))) begin
                r_done <= 1'b0;
            end

            if (w_busy_violation) begin
                r_err <= 1'b1;
            end else if (w_clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign avl.avl_readdata = w_rdata;
    assign o_export_data    = w_ctrl;
    assign o_core_mode      = w_ctrl[CTRL_MODE_LSB +: CTRL_MODE_W];
    assign o_core_start     = r_core_start;
    assign o_irq            = r_done & w_ctrl[CTRL_IRQ_EN_BIT];

endmodule

// File: tb/tb_avalon_ecc_mailbox.sv
// Self-checking bench for avalon_ecc_mailbox with a behavioural core model.
module tb_avalon_ecc_mailbox;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int OW = 8;
    localparam int AW = 5;
    localparam int CORE_LAT = 10;
    localparam logic [AW-1:0] CTRL_A   = 5'd30;
    localparam logic [AW-1:0] STATUS_A = 5'd31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_ecc_mailbox_if #(.DATA_W(DW), .ADDR_W(AW)) avl_bus ();

    logic              irq;
    logic [DW-1:0]     export_data;
    logic              core_start;
    logic [3:0]        core_mode;
    logic [IW*DW-1:0]  core_in;
    logic [OW*DW-1:0]  core_out;
    logic              core_done;
    logic              core_done_r;
    logic              force_done;
    int                core_cnt = 0;
    int                start_cnt = 0;

    int total = 0;
    int bad = 0;

    avalon_ecc_mailbox #(.DATA_W(DW), .IN_WORDS(IW), .OUT_WORDS(OW), .ADDR_W(AW)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .avl           (avl_bus),
        .o_irq         (irq),
        .o_export_data (export_data),
        .o_core_start  (core_start),
        .o_core_mode   (core_mode),
        .o_core_in     (core_in),
        .i_core_out    (core_out),
        .i_core_done   (core_done)
    );

    // Core model: DONE rises CORE_LAT cycles after START and holds until the next START
    always @(posedge clk) begin
        if (rst) begin
            core_done_r <= 1'b0;
            core_cnt    <= 0;
        end else if (core_start) begin
            core_done_r <= 1'b0;
            core_cnt    <= CORE_LAT;
            start_cnt   <= start_cnt + 1;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done_r <= 1'b1;
        end
    end
    assign core_done = core_done_r | force_done;

    // Reference state of the register map
    logic [DW-1:0] m_op [IW];
    logic [DW-1:0] m_res [OW];
    logic [DW-1:0] m_ctrl;
    bit            m_done;
    bit            m_err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    be;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic avl_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        @(negedge clk);
        avl_bus.avl_cs = 1'b1; avl_bus.avl_write = 1'b1;
        avl_bus.avl_addr = a; avl_bus.avl_writedata = d; avl_bus.avl_byte_en = be;
        @(posedge clk); #1;
        avl_bus.avl_cs = 1'b0; avl_bus.avl_write = 1'b0;
    endtask

    task automatic avl_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        avl_bus.avl_cs = 1'b1; avl_bus.avl_read = 1'b1; avl_bus.avl_addr = a;
        @(posedge clk); #1;
        avl_bus.avl_cs = 1'b0; avl_bus.avl_read = 1'b0;
        d = avl_bus.avl_readdata;
    endtask

    task automatic wait_done(input string name);
        logic [DW-1:0] s;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            avl_rd(STATUS_A, s);
            if (s[0]) ok = 1'b1;
        end
        check(name, DW'(ok), 32'd1);
    endtask

    function automatic logic [DW-1:0] word_of(input logic [IW*DW-1:0] v, input int i);
        return v[(IW-1-i)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Idle-time register semantics: operands and CTRL merge, STATUS is W1C
    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        if (int'(a) < IW) m_op[a] = merge(m_op[a], d, be);
        else if (a == CTRL_A) begin
            m_ctrl = merge(m_ctrl, d, be);
            m_ctrl[0] = 1'b0;
        end else if (a == STATUS_A && be[0]) begin
            if (d[0]) m_done = 1'b0;
            if (d[2]) m_err = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (int'(a) < IW) return m_op[a];
        if (int'(a) < IW + OW) return m_res[int'(a) - IW];
        if (a == CTRL_A) return m_ctrl;
        if (a == STATUS_A) return {29'd0, m_err, 1'b0, m_done};
        return 32'd0;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [3:0]    be;
        int            s0;
        bit            seen;

        avl_bus.avl_cs = 1'b0; avl_bus.avl_read = 1'b0; avl_bus.avl_write = 1'b0;
        avl_bus.avl_addr = '0; avl_bus.avl_writedata = '0; avl_bus.avl_byte_en = '0;
        force_done = 1'b0;
        core_out = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("rst_irq", DW'(irq), 32'd0);
        check("rst_export", export_data, 32'd0);
        check("rst_core_start", DW'(core_start), 32'd0);
        avl_rd(STATUS_A, rd); check("rst_status", rd, 32'd0);

        // Table-driven register accesses while idle
        vecs[0] = '{5'd3,  32'hDEADBEEF, 4'b0101, 32'h00AD00EF};
        vecs[1] = '{5'd0,  32'h12345678, 4'b1111, 32'h12345678};
        vecs[2] = '{5'd7,  32'hAABBCCDD, 4'b1000, 32'hAA000000};
        vecs[3] = '{5'd5,  32'h11223344, 4'b0011, 32'h00003344};
        vecs[4] = '{5'd8,  32'hFFFFFFFF, 4'b1111, 32'h00000000};
        vecs[5] = '{5'd15, 32'h0BADF00D, 4'b1111, 32'h00000000};
        vecs[6] = '{5'd20, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
        vecs[7] = '{5'd31, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
        vecs[8] = '{5'd30, 32'h12345672, 4'b1111, 32'h12345672};
        for (int i = 0; i < 9; i++) begin
            avl_wr(vecs[i].addr, vecs[i].data, vecs[i].be);
            avl_rd(vecs[i].addr, rd);
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end
        check("core_in_w3", word_of(core_in, 3), 32'h00AD00EF);
        check("core_in_w0", word_of(core_in, 0), 32'h12345678);
        check("export_ctrl", export_data, 32'h12345672);
        check("core_mode_7", DW'(core_mode), 32'd7);
        check("irq_no_done", DW'(irq), 32'd0);

        // Full run: MODE=2, IRQ_EN, START
        for (int i = 0; i < OW; i++) core_out[(OW-1-i)*DW +: DW] = 32'h100 + i;
        s0 = start_cnt;
        avl_wr(CTRL_A, 32'h00000023, 4'hF);
        avl_rd(STATUS_A, rd); check("run_status_busy", rd, 32'h2);
        check("run_core_mode", DW'(core_mode), 32'd2);
        wait_done("run_done_seen");
        avl_rd(STATUS_A, rd); check("run_status_done", rd, 32'h1);
        check("run_irq", DW'(irq), 32'd1);
        check("run_one_start", start_cnt - s0, 32'd1);
        avl_rd(CTRL_A, rd); check("run_ctrl_start_reads0", rd, 32'h22);
        for (int i = 0; i < OW; i++) begin
            avl_rd(AW'(IW + i), rd);
            check($sformatf("run_res%0d", i), rd, 32'h100 + i);
        end

        // Busy guard: operand write and repeated START are refused and flag ERR
        s0 = start_cnt;
        avl_wr(CTRL_A, 32'h00000023, 4'hF);
        avl_wr(5'd0, 32'hFFFFFFFF, 4'hF);
        avl_wr(CTRL_A, 32'h00000023, 4'hF);
        wait_done("guard_done_seen");
        avl_rd(5'd0, rd); check("guard_op_kept", rd, 32'h12345678);
        check("guard_one_start", start_cnt - s0, 32'd1);
        avl_rd(STATUS_A, rd); check("guard_status_err", rd, 32'h5);
        avl_wr(STATUS_A, 32'h00000004, 4'hF);
        avl_rd(STATUS_A, rd); check("guard_err_w1c", rd, 32'h1);

        // W1C of DONE landing on the capture cycle: set wins
        avl_wr(CTRL_A, 32'h00000023, 4'hF);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (!core_done) seen = 1'b1;
        end
        check("cap_done_fell", DW'(seen), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (core_done) seen = 1'b1;
        end
        check("cap_done_rose", DW'(seen), 32'd1);
        @(posedge clk);
        avl_wr(STATUS_A, 32'h00000001, 4'hF);
        avl_rd(STATUS_A, rd); check("cap_set_wins", rd, 32'h1);
        check("cap_irq", DW'(irq), 32'd1);

        // Reset in the middle of a run, then a late CORE_DONE
        for (int i = 0; i < OW; i++) core_out[(OW-1-i)*DW +: DW] = 32'hBAD0 + i;
        s0 = start_cnt;
        avl_wr(CTRL_A, 32'h00000023, 4'hF);
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) begin rst = 1'b0; force_done = 1'b1; end
        repeat (3) @(posedge clk);
        avl_rd(5'd8, rd);  check("rstmid_res0", rd, 32'd0);
        avl_rd(5'd15, rd); check("rstmid_res7", rd, 32'd0);
        avl_rd(STATUS_A, rd); check("rstmid_status_idle", rd, 32'd0);
        check("rstmid_irq", DW'(irq), 32'd0);
        check("rstmid_starts", start_cnt - s0, 32'd1);
        @(negedge clk) force_done = 1'b0;

        // Randomized idle accesses against the reference model
        for (int i = 0; i < IW; i++) m_op[i] = '0;
        for (int i = 0; i < OW; i++) m_res[i] = '0;
        m_ctrl = '0; m_done = 1'b0; m_err = 1'b0;
        for (int it = 0; it < 150; it++) begin
            a  = AW'($urandom_range(0, 31));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                if (a == CTRL_A) d[0] = 1'b0;
                avl_wr(a, d, be);
                model_write(a, d, be);
            end else begin
                avl_rd(a, rd);
                check($sformatf("rand_rd_addr%0d", a), rd, model_read(a));
            end
        end

        // Randomized runs: operands, mode and results checked end to end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < OW; i++) begin
                d = $urandom;
                m_res[i] = d;
                core_out[(OW-1-i)*DW +: DW] = d;
            end
            d = $urandom;
            d[0] = 1'b1;
            s0 = start_cnt;
            avl_wr(CTRL_A, d, 4'hF);
            m_ctrl = d; m_ctrl[0] = 1'b0; m_done = 1'b0;
            check("rrun_mode", DW'(core_mode), DW'(m_ctrl[7:4]));
            for (int i = 0; i < IW; i++)
                check($sformatf("rrun_core_in%0d", i), word_of(core_in, i), m_op[i]);
            wait_done("rrun_done_seen");
            m_done = 1'b1;
            check("rrun_one_start", start_cnt - s0, 32'd1);
            check("rrun_export", export_data, m_ctrl);
            check("rrun_irq", DW'(irq), DW'(m_done & m_ctrl[1]));
            for (int i = 0; i < OW; i++) begin
                avl_rd(AW'(IW + i), rd);
                check($sformatf("rrun_res%0d", i), rd, m_res[i]);
            end
            avl_rd(STATUS_A, rd); check("rrun_status", rd, model_read(STATUS_A));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_ecc_mailbox.md
Name: avalon_ecc_mailbox

Overview:
Parametrised Avalon-MM slave mailbox between the NIOS console software and an ECC compute core.
- Software writes IN_WORDS operand words, sets MODE, writes START, then polls STATUS or takes IRQ.
- Block sequences the core start/done handshake and captures the OUT_WORDS result into read-only registers.
- Adds over the previous console interface: busy guard, sticky W1C done, error flag, interrupt, registered read data.

Parameters:
DATA_W, 32, width of one register word and of the Avalon data bus
IN_WORDS, 8, operand words (software to core)
OUT_WORDS, 8, result words (core to software)
ADDR_W, 5, Avalon word address width; IN_WORDS+OUT_WORDS must be at most 2**ADDR_W-2

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
AVL_READ  in  1  Avalon-MM read
AVL_WRITE  in  1  Avalon-MM write
AVL_CS  in  1  chip select; read/write ignored when low
AVL_BYTE_EN  in  DATA_W/8  byte enables for writes
AVL_ADDR  in  ADDR_W  word address
AVL_WRITEDATA  in  DATA_W  write data
AVL_READDATA  out  DATA_W  read data, registered
IRQ  out  1  level interrupt = STATUS.DONE & CTRL.IRQ_EN
EXPORT_DATA  out  DATA_W  mirror of CTRL register (LED/hex debug)
CORE_START  out  1  one-cycle start pulse to core
CORE_MODE  out  4  operation select = CTRL[7:4]
CORE_IN  out  IN_WORDS*DATA_W  operand words; word 0 in MSBs
CORE_OUT  in  OUT_WORDS*DATA_W  result words; word 0 in MSBs
CORE_DONE  in  1  core result valid; held high until next CORE_START

Behaviour:
- Register map:
  - 0..IN_WORDS-1: operand, R/W.
  - IN_WORDS..IN_WORDS+OUT_WORDS-1: result, RO.
  - 2**ADDR_W-2: CTRL.
  - 2**ADDR_W-1: STATUS.
  - Unmapped addresses read 0; writes to them are dropped.
- CTRL bits:
  - bit0 START: write-1 trigger; reads 0.
  - bit1 IRQ_EN: R/W.
  - [7:4] MODE: R/W.
  - All other bits: R/W scratch.
- STATUS bits:
  - bit0 DONE: sticky; write-1-to-clear.
  - bit1 BUSY: RO.
  - bit2 ERR: sticky; W1C.
  - Other bits read 0.
- Writes apply per byte under AVL_BYTE_EN, and only when AVL_CS & AVL_WRITE.
- Read latency 1: AVL_READDATA is updated the cycle after AVL_CS & AVL_READ and holds its value otherwise.
- FSM states: IDLE, LAUNCH, BUSY, CAPTURE.
  - IDLE: a write of START=1 (byte 0 enabled) goes to LAUNCH and clears DONE in the same cycle.
  - LAUNCH: CORE_START=1 for exactly this cycle; next state BUSY.
  - BUSY: waits for CORE_DONE=1, then goes to CAPTURE. No timeout.
  - CAPTURE: load all result registers from CORE_OUT, set DONE; next state IDLE.
  - Start-to-DONE visible: 3 cycles + core latency.
- BUSY flag is 1 in LAUNCH, BUSY and CAPTURE.
- Operand or MODE writes while BUSY=1: write dropped, ERR set.
- START while BUSY=1: ignored, ERR set, no second CORE_START.
- Simultaneous W1C of DONE and CAPTURE setting DONE: set wins; same rule for ERR.
- CORE_IN and CORE_MODE are driven from the registers continuously and are stable from LAUNCH through CAPTURE.
- Reset values:
  - All registers, AVL_READDATA, IRQ, EXPORT_DATA and CORE_START are 0.
  - FSM goes to IDLE.
  - Reset mid-operation abandons the run with no capture; the core shares RESET.

Decomposition:
- Package ecc_mailbox_pkg holds:
  - mbox_state_e enum (IDLE, LAUNCH, BUSY, CAPTURE).
  - CTRL/STATUS bit-index localparams.
  - Offset helper functions for the CTRL/STATUS addresses.
- One sub-module, mbox_regfile: byte-enabled operand/result/CTRL storage plus the read mux.
- The FSM and STATUS flags stay in the top module.

Test Plan:
- Reset then read addr 31 -> AVL_READDATA=0 one cycle later; IRQ=0; EXPORT_DATA=0.
- Write 0xDEADBEEF to addr 3 with BYTE_EN=4'b0101 -> read addr 3 returns 0x00AD00EF; CORE_IN word 3 matches.
- Write CTRL=0x23 (MODE=2, IRQ_EN, START); core model asserts CORE_DONE 10 cycles after CORE_START with result words 0x100+i:
  - CORE_START pulses exactly once; CORE_MODE=2.
  - STATUS reads 0x2 while running, then 0x1.
  - IRQ=1; addr 8+i reads 0x100+i.
- During BUSY, write addr 0 and write START -> operand unchanged, single CORE_START, STATUS.ERR=1. Write STATUS=0x4 -> ERR clears and DONE is unaffected.
- Write STATUS=0x1 in the same cycle as CAPTURE -> DONE remains 1.
- Assert RESET while in BUSY, then raise CORE_DONE -> result registers stay 0, DONE=0, FSM in IDLE.
